noc_traffic_gen: RTL and testbench

- Synthesizable, parametrised NoC traffic generator with one independent injector channel per network node.
- Drives the router input-side flit interfaces (valid/ready) of the noc top.
- Supports configurable packet length, injection rate and destination pattern, with per-channel packet/flit counters.
- Replaces hand-driven stimulus for emulation runs and directed UVM smoke runs.

---
 rtl/noc_traffic_gen_pkg.sv | 50 +++++
 rtl/noc_traffic_gen_if.sv | 12 +
 rtl/noc_traffic_gen_chan.sv | 132 +++++++++++++
 rtl/noc_traffic_gen.sv | 52 +++++
 tb/tb_noc_traffic_gen.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/noc_traffic_gen_pkg.sv
// Shared types and flit packing helpers for the NoC traffic generator.
// Flit layout, MSB first: type[1:0] | dest[ID_W] | src[ID_W] | payload.
package noc_traffic_gen_pkg;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    TG_UNIFORM   = 2'd0,
    TG_TRANSPOSE = 2'd1,
    TG_HOTSPOT   = 2'd2,
    TG_NEIGHBOUR = 2'd3
  } tg_mode_e;

  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [15:0] SEED_STRIDE = 16'h9E37;
  localparam int          TYPE_W      = 2;
  localparam int          SEQ_W       = 16;
  localparam int          PACK_MAX_W  = 128;

  function automatic int type_lsb(int flit_w);
    return flit_w - TYPE_W;
  endfunction

  function automatic int dest_lsb(int flit_w, int id_w);
    return flit_w - TYPE_W - id_w;
  endfunction

  function automatic int src_lsb(int flit_w, int id_w);
    return flit_w - TYPE_W - 2 * id_w;
  endfunction

  // Result is left wide; callers truncate to their FLIT_W. dest/src must be
  // zero above id_w.
  function automatic logic [PACK_MAX_W-1:0] pack_flit(flit_type_e t, logic [7:0] dest,
                                                      logic [7:0] src, logic [SEQ_W-1:0] payload,
                                                      int flit_w, int id_w);
    logic [PACK_MAX_W-1:0] f;
    f = PACK_MAX_W'(payload);
    f = f | (PACK_MAX_W'(src) << src_lsb(flit_w, id_w));
    f = f | (PACK_MAX_W'(dest) << dest_lsb(flit_w, id_w));
    f = f | (PACK_MAX_W'(t) << type_lsb(flit_w));
    return f;
  endfunction

endpackage

// File: rtl/noc_traffic_gen_if.sv
// Router-input flit bus: one valid/ready flit channel per node, flattened.
interface noc_traffic_gen_if #(
  parameter int N_NODES = 4,
  parameter int FLIT_W  = 32
);
  logic [N_NODES*FLIT_W-1:0] flit;
  logic [N_NODES-1:0]        valid;
  logic [N_NODES-1:0]        ready;

  modport master (output flit, output valid, input ready);
  modport slave  (input flit, input valid, output ready);
endinterface

// File: rtl/noc_traffic_gen_chan.sv
// One injector channel: free-running LFSR, packet FSM, registered flit
// output and packet/flit counters.
module noc_traffic_gen_chan
  import noc_traffic_gen_pkg::*;
#(
  parameter int          N_NODES    = 4,
  parameter int          FLIT_W     = 32,
  parameter int          PKT_LEN    = 4,
  parameter int          CHAN_ID    = 0,
  parameter int          HOTSPOT_ID = 0,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic [1:0]        mode_i,
  input  logic [7:0]        rate_i,
  input  logic              ready_i,
  output logic [FLIT_W-1:0] flit_o,
  output logic              valid_o,
  output logic [31:0]       pkt_cnt_o,
  output logic [31:0]       flit_cnt_o,
  output logic              idle_o
);
  localparam int ID_W = $clog2(N_NODES);
  localparam logic [15:0] SEED_SUM  = SEED + SEED_STRIDE * 16'(CHAN_ID + 1);
  localparam logic [15:0] LFSR_INIT = (SEED_SUM == 16'h0000) ? 16'h0001 : SEED_SUM;
  localparam logic [ID_W-1:0] SELF  = ID_W'(CHAN_ID);
  localparam logic [ID_W-1:0] NEXT  = ID_W'((CHAN_ID + 1) % N_NODES);
  localparam logic [ID_W-1:0] TRANS = ID_W'(N_NODES - 1 - CHAN_ID);
  localparam logic [ID_W-1:0] HOT   = (CHAN_ID == HOTSPOT_ID) ?
                                      ID_W'((HOTSPOT_ID + 1) % N_NODES) : ID_W'(HOTSPOT_ID);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HEAD   = 3'd1;
  localparam logic [2:0] S_BODY   = 3'd2;
  localparam logic [2:0] S_TAIL   = 3'd3;
  localparam logic [2:0] S_SINGLE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       seq_q, seq_d;
  logic [15:0]       idx_q, idx_d, nidx;
  logic              valid_q, valid_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic [31:0]       pkt_q, pkt_d, fcnt_q, fcnt_d;
  logic [ID_W-1:0]   dest_q, dest_d, rnd_dest, dest_sel;
  logic              inject, xfer;

  function automatic logic [FLIT_W-1:0] mk(flit_type_e t, logic [ID_W-1:0] d, logic [15:0] pl);
    return FLIT_W'(pack_flit(t, 8'(d), 8'(SELF), pl, FLIT_W, ID_W));
  endfunction

  always_comb begin
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    rnd_dest = lfsr_q[15 -: ID_W];
    case (tg_mode_e'(mode_i))
      TG_UNIFORM:   dest_sel = (rnd_dest == SELF) ? NEXT : rnd_dest;
      TG_TRANSPOSE: dest_sel = TRANS;
      TG_HOTSPOT:   dest_sel = HOT;
      default:      dest_sel = NEXT;
    endcase
    inject  = enable_i && (rate_i == 8'hFF || lfsr_q[7:0] < rate_i);
    xfer    = valid_q && ready_i;
    nidx    = idx_q + 16'd1;
    state_d = state_q;
    valid_d = valid_q;
    flit_d  = flit_q;
    dest_d  = dest_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    pkt_d   = pkt_q;
    fcnt_d  = fcnt_q + 32'(xfer);
    case (state_q)
      S_IDLE: if (inject) begin
        dest_d  = dest_sel;
        idx_d   = 16'd0;
        valid_d = 1'b1;
        state_d = (PKT_LEN == 1) ? S_SINGLE : S_HEAD;
        flit_d  = mk((PKT_LEN == 1) ? FT_SINGLE : FT_HEAD, dest_sel, seq_q);
      end
      S_HEAD, S_BODY: if (xfer) begin
        // body/tail payload carries the flit index within the packet
        idx_d = nidx;
        if (nidx == 16'(PKT_LEN - 1)) begin
          state_d = S_TAIL;
          flit_d  = mk(FT_TAIL, dest_q, nidx);
        end else begin
          state_d = S_BODY;
          flit_d  = mk(FT_BODY, dest_q, nidx);
        end
      end
      default: if (xfer) begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        seq_d   = seq_q + 16'd1;
        pkt_d   = pkt_q + 32'd1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_INIT;
      valid_q <= 1'b0;
      flit_q  <= '0;
      dest_q  <= '0;
      idx_q   <= '0;
      seq_q   <= '0;
      pkt_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      valid_q <= valid_d;
      flit_q  <= flit_d;
      dest_q  <= dest_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      pkt_q   <= pkt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign flit_o     = flit_q;
  assign valid_o    = valid_q;
  assign pkt_cnt_o  = pkt_q;
  assign flit_cnt_o = fcnt_q;
  assign idle_o     = (state_q == S_IDLE);

endmodule

// File: rtl/noc_traffic_gen.sv
// NoC traffic generator: N_NODES independent injector channels driving the
// router input flit bus, plus a global idle indication.
module noc_traffic_gen
  import noc_traffic_gen_pkg::*;
#(
  parameter int          N_NODES    = 4,
  parameter int          FLIT_W     = 32,
  parameter int          PKT_LEN    = 4,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          HOTSPOT_ID = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic [1:0]            mode_i,
  input  logic [7:0]            rate_i,
  noc_traffic_gen_if.master     tx,
  output logic [N_NODES*32-1:0] pkt_cnt_o,
  output logic [N_NODES*32-1:0] flit_cnt_o,
  output logic                  idle_o
);
  logic [N_NODES-1:0][FLIT_W-1:0] flit_w;
  logic [N_NODES-1:0]             valid_w;
  logic [N_NODES-1:0][31:0]       pkt_w, fcnt_w;
  logic [N_NODES-1:0]             chan_idle;

  for (genvar p = 0; p < N_NODES; p++) begin : g_chan
    noc_traffic_gen_chan #(
      .N_NODES(N_NODES), .FLIT_W(FLIT_W), .PKT_LEN(PKT_LEN),
      .CHAN_ID(p), .HOTSPOT_ID(HOTSPOT_ID), .SEED(SEED)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable_i  (enable_i),
      .mode_i    (mode_i),
      .rate_i    (rate_i),
      .ready_i   (tx.ready[p]),
      .flit_o    (flit_w[p]),
      .valid_o   (valid_w[p]),
      .pkt_cnt_o (pkt_w[p]),
      .flit_cnt_o(fcnt_w[p]),
      .idle_o    (chan_idle[p])
    );
  end

  assign tx.flit    = flit_w;
  assign tx.valid   = valid_w;
  assign pkt_cnt_o  = pkt_w;
  assign flit_cnt_o = fcnt_w;
  assign idle_o     = (&chan_idle) && !enable_i;

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Directed bench for noc_traffic_gen (4 nodes, 32-bit flits, 4-flit packets).
module tb_noc_traffic_gen;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable;
  logic [1:0]   mode;
  logic [7:0]   rate;
  logic [127:0] pkt_cnt, flit_cnt;
  logic         idle;
  int           n_chk = 0;
  int           n_pass = 0;

  noc_traffic_gen_if #(.N_NODES(4), .FLIT_W(32)) bus ();

  noc_traffic_gen dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .mode_i(mode), .rate_i(rate),
    .tx(bus.master), .pkt_cnt_o(pkt_cnt), .flit_cnt_o(flit_cnt), .idle_o(idle)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fl(int p);
    return bus.flit[p*32 +: 32];
  endfunction
  function automatic logic [31:0] pc(int p);
    return pkt_cnt[p*32 +: 32];
  endfunction
  function automatic logic [31:0] fc(int p);
    return flit_cnt[p*32 +: 32];
  endfunction
  function automatic logic [31:0] mkf(logic [1:0] t, int d, int s, int pl);
    return {t, 2'(d), 2'(s), 26'(pl)};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; bus.ready = 4'hF; mode = 2'd3; rate = 8'hFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] exp_seed;
    exp_seed = 16'hACE1 + 16'h9E37;
    rst_n = 1'b0; enable = 1'b0; bus.ready = 4'hF; mode = 2'd3; rate = 8'hFF;
    #10;
    n_chk++; if (bus.valid !== 4'h0) $display("FAIL reset_valid got %h exp 0", bus.valid); else n_pass++;
    n_chk++; if (bus.flit !== 128'h0) $display("FAIL reset_flit got %h exp 0", bus.flit); else n_pass++;
    n_chk++; if (pkt_cnt !== 128'h0) $display("FAIL reset_pkt_cnt got %h exp 0", pkt_cnt); else n_pass++;
    n_chk++; if (flit_cnt !== 128'h0) $display("FAIL reset_flit_cnt got %h exp 0", flit_cnt); else n_pass++;
    n_chk++; if (idle !== 1'b1) $display("FAIL reset_idle got %b exp 1", idle); else n_pass++;
    @(negedge clk); rst_n = 1'b1; #1;
    n_chk++; if (dut.g_chan[0].u_chan.lfsr_q !== exp_seed)
      $display("FAIL reset_lfsr0 got %h exp %h", dut.g_chan[0].u_chan.lfsr_q, exp_seed); else n_pass++;
    n_chk++; if (idle !== 1'b1) $display("FAIL release_idle got %b exp 1", idle); else n_pass++;
  endtask

  task automatic test_stream();
    int idx[4], seq[4], npk[4], nfl[4];
    bit ev[4];
    bit en_next;
    logic [31:0] exp;
    do_reset();
    for (int p = 0; p < 4; p++) begin idx[p] = 0; seq[p] = 0; npk[p] = 0; nfl[p] = 0; ev[p] = 1'b1; end
    enable = 1'b1;
    for (int cyc = 0; cyc < 130; cyc++) begin
      @(negedge clk);
      en_next = (cyc < 99);
      for (int p = 0; p < 4; p++) begin
        n_chk++; if (fc(p) !== 32'(nfl[p]))
          $display("FAIL stream_flit_cnt ch%0d cyc%0d got %0d exp %0d", p, cyc, fc(p), nfl[p]); else n_pass++;
        n_chk++; if (pc(p) !== 32'(npk[p]))
          $display("FAIL stream_pkt_cnt ch%0d cyc%0d got %0d exp %0d", p, cyc, pc(p), npk[p]); else n_pass++;
        n_chk++; if (bus.valid[p] !== ev[p])
          $display("FAIL stream_valid ch%0d cyc%0d got %b exp %b", p, cyc, bus.valid[p], ev[p]); else n_pass++;
        if (ev[p]) begin
          exp = mkf(idx[p] == 0 ? 2'b01 : (idx[p] == 3 ? 2'b10 : 2'b00), (p + 1) % 4, p,
                    idx[p] == 0 ? seq[p] : idx[p]);
          n_chk++; if (fl(p) !== exp)
            $display("FAIL stream_flit ch%0d cyc%0d got %h exp %h", p, cyc, fl(p), exp); else n_pass++;
          nfl[p]++;
          if (idx[p] == 3) begin npk[p]++; seq[p]++; idx[p] = 0; ev[p] = 1'b0; end
          else idx[p]++;
        end else ev[p] = en_next;
      end
      enable = en_next;
    end
    n_chk++; if (idle !== 1'b1) $display("FAIL stream_idle got %b exp 1", idle); else n_pass++;
    for (int p = 0; p < 4; p++) begin
      n_chk++; if (pc(p) !== 32'd20) $display("FAIL stream_total_pkts ch%0d got %0d exp 20", p, pc(p)); else n_pass++;
      n_chk++; if (fc(p) !== 32'd80) $display("FAIL stream_total_flits ch%0d got %0d exp 80", p, fc(p)); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    enable = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (fl(1) !== 32'h2400_0001) $display("FAIL bp_first_body got %h exp 24000001", fl(1)); else n_pass++;
    bus.ready = 4'hD;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_chk++; if (bus.valid[1] !== 1'b1) $display("FAIL bp_valid_hold cyc%0d got %b exp 1", i, bus.valid[1]); else n_pass++;
      n_chk++; if (fl(1) !== 32'h2400_0001) $display("FAIL bp_flit_hold cyc%0d got %h exp 24000001", i, fl(1)); else n_pass++;
      n_chk++; if (fc(1) !== 32'd1) $display("FAIL bp_cnt_hold cyc%0d got %0d exp 1", i, fc(1)); else n_pass++;
    end
    n_chk++; if (fc(0) !== 32'd17) $display("FAIL bp_other_ch0 got %0d exp 17", fc(0)); else n_pass++;
    n_chk++; if (fc(2) !== 32'd17) $display("FAIL bp_other_ch2 got %0d exp 17", fc(2)); else n_pass++;
    bus.ready = 4'hF; enable = 1'b0;
    repeat (8) @(negedge clk);
    n_chk++; if (pc(1) !== 32'd1) $display("FAIL bp_pkt_ch1 got %0d exp 1", pc(1)); else n_pass++;
    n_chk++; if (fc(1) !== 32'd4) $display("FAIL bp_flit_ch1 got %0d exp 4", fc(1)); else n_pass++;
    n_chk++; if (pc(0) !== 32'd5) $display("FAIL bp_pkt_ch0 got %0d exp 5", pc(0)); else n_pass++;
    n_chk++; if (fc(0) !== 32'd20) $display("FAIL bp_flit_ch0 got %0d exp 20", fc(0)); else n_pass++;
    n_chk++; if (idle !== 1'b1) $display("FAIL bp_idle got %b exp 1", idle); else n_pass++;
  endtask

  task automatic test_modes();
    do_reset();
    mode = 2'd2; enable = 1'b1;
    @(negedge clk);
    n_chk++; if (fl(0) !== 32'h5000_0000) $display("FAIL hot_ch0 got %h exp 50000000", fl(0)); else n_pass++;
    n_chk++; if (fl(1) !== 32'h4400_0000) $display("FAIL hot_ch1 got %h exp 44000000", fl(1)); else n_pass++;
    n_chk++; if (fl(2) !== 32'h4800_0000) $display("FAIL hot_ch2 got %h exp 48000000", fl(2)); else n_pass++;
    n_chk++; if (fl(3) !== 32'h4C00_0000) $display("FAIL hot_ch3 got %h exp 4c000000", fl(3)); else n_pass++;
    enable = 1'b0; mode = 2'd1;
    @(negedge clk);
    n_chk++; if (fl(0) !== 32'h1000_0001) $display("FAIL latched_dest_ch0 got %h exp 10000001", fl(0)); else n_pass++;
    n_chk++; if (fl(1) !== 32'h0400_0001) $display("FAIL latched_dest_ch1 got %h exp 04000001", fl(1)); else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++; if (idle !== 1'b1) $display("FAIL modes_idle got %b exp 1", idle); else n_pass++;
    enable = 1'b1;
    @(negedge clk);
    n_chk++; if (fl(0) !== 32'h7000_0001) $display("FAIL trans_ch0 got %h exp 70000001", fl(0)); else n_pass++;
    n_chk++; if (fl(1) !== 32'h6400_0001) $display("FAIL trans_ch1 got %h exp 64000001", fl(1)); else n_pass++;
    n_chk++; if (fl(2) !== 32'h5800_0001) $display("FAIL trans_ch2 got %h exp 58000001", fl(2)); else n_pass++;
    n_chk++; if (fl(3) !== 32'h4C00_0001) $display("FAIL trans_ch3 got %h exp 4c000001", fl(3)); else n_pass++;
    enable = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_enable_drop();
    do_reset();
    rate = 8'h00; enable = 1'b1;
    repeat (8) @(negedge clk);
    n_chk++; if (bus.valid !== 4'h0) $display("FAIL rate0_valid got %h exp 0", bus.valid); else n_pass++;
    rate = 8'hFF;
    @(negedge clk);
    n_chk++; if (fl(0) !== 32'h5000_0000) $display("FAIL drop_head got %h exp 50000000", fl(0)); else n_pass++;
    enable = 1'b0;
    @(negedge clk);
    n_chk++; if (fl(0) !== 32'h1000_0001) $display("FAIL drop_body1 got %h exp 10000001", fl(0)); else n_pass++;
    n_chk++; if (idle !== 1'b0) $display("FAIL drop_idle_body got %b exp 0", idle); else n_pass++;
    @(negedge clk);
    n_chk++; if (fl(0) !== 32'h1000_0002) $display("FAIL drop_body2 got %h exp 10000002", fl(0)); else n_pass++;
    @(negedge clk);
    n_chk++; if (fl(0) !== 32'h9000_0003) $display("FAIL drop_tail got %h exp 90000003", fl(0)); else n_pass++;
    n_chk++; if (bus.valid !== 4'hF) $display("FAIL drop_tail_valid got %h exp f", bus.valid); else n_pass++;
    n_chk++; if (idle !== 1'b0) $display("FAIL drop_idle_tail got %b exp 0", idle); else n_pass++;
    @(negedge clk);
    n_chk++; if (idle !== 1'b1) $display("FAIL drop_idle_after got %b exp 1", idle); else n_pass++;
    n_chk++; if (pc(0) !== 32'd1) $display("FAIL drop_pkt got %0d exp 1", pc(0)); else n_pass++;
    n_chk++; if (fc(0) !== 32'd4) $display("FAIL drop_flits got %0d exp 4", fc(0)); else n_pass++;
    repeat (5) @(negedge clk);
    n_chk++; if (bus.valid !== 4'h0) $display("FAIL drop_no_new_head got %h exp 0", bus.valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (bus.valid[2] !== 1'b1) $display("FAIL rmid_pre_valid got %b exp 1", bus.valid[2]); else n_pass++;
    rst_n = 1'b0; #1;
    n_chk++; if (bus.valid !== 4'h0) $display("FAIL rmid_async_valid got %h exp 0", bus.valid); else n_pass++;
    n_chk++; if (fc(2) !== 32'd0) $display("FAIL rmid_cnt got %0d exp 0", fc(2)); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (fl(2) !== 32'h7800_0000) $display("FAIL rmid_head got %h exp 78000000", fl(2)); else n_pass++;
    n_chk++; if (pc(2) !== 32'd0) $display("FAIL rmid_pkt got %0d exp 0", pc(2)); else n_pass++;
    enable = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    enable = 1'b0; mode = 2'd3; rate = 8'hFF; bus.ready = 4'hF;
    test_reset();
    test_stream();
    test_backpressure();
    test_modes();
    test_enable_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
